// File: rtl/round_ctrl.sv
// round_ctrl: per-frame round sequencer for the two-tank game.
// Gates keycodes, issues respawn pulses, keeps scores, runs respawn delay, declares winner.
//
// Ports:
//   frame_clk      frame-rate clock, all state changes on its rising edge
//   Reset          synchronous active-high reset
//   start          start/restart key (level, rising-edge detected)
//   pause          pause key (level, rising-edge detected), only with ROUND_PAUSE_EN
//   p1_hit/p2_hit  tank struck this frame (level)
//   p*_keycode_in  raw keycodes; p*_keycode gated keycodes (live only in PLAY)
//   p*_was_hit     one-frame respawn pulses to the tank movers
//   p*_score       per-player scores
//   winner         00 none, 01 tank 1, 10 tank 2
//   state          000 IDLE, 001 PLAY, 010 RESPAWN, 011 GAMEOVER, 100 PAUSED
//
// Build option: define ROUND_PAUSE_EN to add the pause port and PAUSED state.
module round_ctrl #(
  parameter int RESPAWN_FRAMES = 60,
  parameter int WIN_SCORE      = 5,
  parameter int SCORE_W        = 4
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               start,
`ifdef ROUND_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               p1_hit,
  input  logic               p2_hit,
  input  logic [7:0]         p1_keycode_in,
  input  logic [7:0]         p2_keycode_in,
  output logic [7:0]         p1_keycode,
  output logic [7:0]         p2_keycode,
  output logic               p1_was_hit,
  output logic               p2_was_hit,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam int CNT_W =
    (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_PLAY     = 3'b001,
    S_RESPAWN  = 3'b010,
    S_GAMEOVER = 3'b011,
    S_PAUSED   = 3'b100
  } state_t;

  state_t             st_q, st_d;
  logic [SCORE_W-1:0] s1_q, s1_d;
  logic [SCORE_W-1:0] s2_q, s2_d;
  logic [1:0]         win_q, win_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q;
  logic               start_rise;

  assign start_rise = start & ~start_q;

`ifdef ROUND_PAUSE_EN
  logic pause_q;
  logic pause_rise;

  assign pause_rise = pause & ~pause_q;

  always_ff @(posedge frame_clk) begin
    if (Reset) pause_q <= 1'b0;
    else       pause_q <= pause;
  end
`endif

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      st_q    <= S_IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      win_q   <= 2'b00;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      win_q   <= win_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      start_q <= start;
    end
  end

  always_comb begin
    st_d  = st_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    win_d = win_q;
    hit_d = 1'b0;
    cnt_d = cnt_q;
    case (st_q)
      S_IDLE: begin
        if (start_rise) begin
          st_d  = S_PLAY;
          s1_d  = '0;
          s2_d  = '0;
          win_d = 2'b00;
          hit_d = 1'b1;
        end
      end
      S_PLAY: begin
        // A hit in the spawn frame right after a pulse is dropped so
        // the respawn pulse can never be two frames long.
        if ((p1_hit | p2_hit) & ~hit_q) begin
          hit_d = 1'b1;
          if (p2_hit & ~p1_hit) s1_d = s1_q + 1'b1;
          if (p1_hit & ~p2_hit) s2_d = s2_q + 1'b1;
          if (s1_d == WIN) begin
            st_d  = S_GAMEOVER;
            win_d = 2'b01;
          end else if (s2_d == WIN) begin
            st_d  = S_GAMEOVER;
            win_d = 2'b10;
          end else begin
            st_d  = S_RESPAWN;
            cnt_d = CNT_LOAD;
          end
        end
`ifdef ROUND_PAUSE_EN
        else if (pause_rise) begin
          st_d = S_PAUSED;
        end
`endif
      end
      S_RESPAWN: begin
        if (cnt_q == '0) st_d = S_PLAY;
        else             cnt_d = cnt_q - 1'b1;
      end
      S_GAMEOVER: begin
        if (start_rise) st_d = S_IDLE;
      end
`ifdef ROUND_PAUSE_EN
      S_PAUSED: begin
        if (pause_rise) st_d = S_PLAY;
      end
`endif
      default: st_d = S_IDLE;
    endcase
  end

  assign p1_keycode = (st_q == S_PLAY) ? p1_keycode_in : 8'h00;
  assign p2_keycode = (st_q == S_PLAY) ? p2_keycode_in : 8'h00;
  assign p1_was_hit = hit_q;
  assign p2_was_hit = hit_q;
  assign p1_score   = s1_q;
  assign p2_score   = s2_q;
  assign winner     = win_q;
  assign state      = st_q;

endmodule
